multiport_register_file: RTL and testbench

// - Parametrised multi-port general-purpose register file: NRD read ports, NWR write ports.
// - Optional hardwired-zero register 0; deterministic write-port priority on collisions.
// - Sits in the datapath decode/writeback stages.
// - Successor to the single-write, dual-read file: generalises width, depth and port counts.

---
 rtl/multiport_register_file.sv | 137 +++++++++++++
 tb/tb_multiport_register_file.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/multiport_register_file.sv
// multiport_register_file: NRD combinational read ports, NWR write ports.
// Lower write-port index wins when several ports target the same register;
// losers raise wcoll for one cycle. Optional hardwired-zero register 0.
// Build option: define RF_BYPASS_EN to forward the winning write data to a
// read port addressing the same register in the same cycle.

// One read lane: array mux, optional forward, hardwired zero.
module rf_read_lane #(
    parameter int DW    = 32,
    parameter int NREG  = 32,
    parameter int ZERO0 = 1,
    parameter int AW    = 5
) (
    input  logic [NREG-1:0][DW-1:0] mem,
    input  logic [AW-1:0]           rsel,
    input  logic                    fwd_hit,
    input  logic [DW-1:0]           fwd_dat,
    output logic [DW-1:0]           rdat
);

    // Forwarded data takes precedence over the array; reg 0 masks everything.
    always_comb begin
        rdat = fwd_hit ? fwd_dat : mem[rsel];
        if (ZERO0 != 0 && rsel == '0)
            rdat = '0;
    end

endmodule

module multiport_register_file #(
    parameter int DW    = 32,
    parameter int NREG  = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    parameter int ZERO0 = 1,
    localparam int AW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [NWR-1:0]    wen,
    input  logic [NWR*AW-1:0] wsel,
    input  logic [NWR*DW-1:0] wdat,
    input  logic [NRD*AW-1:0] rsel,
    output logic [NRD*DW-1:0] rdat,
    output logic [NWR-1:0]    wcoll,
    output logic [15:0]       wcnt
);

    logic [NREG-1:0][DW-1:0] mem;
    logic [NWR-1:0]          win;
    logic [NWR-1:0]          drop;
    logic [NWR-1:0]          commit;
    logic [16:0]             ncommit;
    logic [16:0]             wsum;
    logic [NRD-1:0]          fwd_hit;
    logic [NRD-1:0][DW-1:0]  fwd_dat;

    // Arbitration: a port wins unless a lower-index enabled port shares its
    // index. A win on reg 0 with ZERO0 still blocks others but stores nothing.
    always_comb begin
        for (int p = 0; p < NWR; p++) begin
            win[p] = wen[p];
            for (int q = 0; q < p; q++) begin
                if (wen[q] && wsel[q*AW +: AW] == wsel[p*AW +: AW])
                    win[p] = 1'b0;
            end
            drop[p]   = wen[p] && !win[p];
            commit[p] = win[p] && !(ZERO0 != 0 && wsel[p*AW +: AW] == '0);
        end
    end

    // Committed-write tally for this edge and the saturating sum.
    always_comb begin
        ncommit = '0;
        for (int p = 0; p < NWR; p++)
            ncommit = ncommit + 17'(commit[p]);
        wsum = {1'b0, wcnt} + ncommit;
    end

    // Register array update; winners are unique per index so order is moot.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            mem <= '0;
        end else begin
            for (int p = NWR - 1; p >= 0; p--) begin
                if (commit[p])
                    mem[wsel[p*AW +: AW]] <= wdat[p*DW +: DW];
            end
        end
    end

    // Collision flags and write counter, both registered.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            wcoll <= '0;
            wcnt  <= '0;
        end else begin
            wcoll <= drop;
            wcnt  <= wsum[16] ? 16'hFFFF : wsum[15:0];
        end
    end

    genvar r;
    generate
        for (r = 0; r < NRD; r++) begin : g_rd
`ifdef RF_BYPASS_EN
            // Forward the (unique) winning write on this lane's index.
            always_comb begin
                fwd_hit[r] = 1'b0;
                fwd_dat[r] = '0;
                for (int p = 0; p < NWR; p++) begin
                    if (!n_rst && win[p] && wsel[p*AW +: AW] == rsel[r*AW +: AW]) begin
                        fwd_hit[r] = 1'b1;
                        fwd_dat[r] = wdat[p*DW +: DW];
                    end
                end
            end
`else
            assign fwd_hit[r] = 1'b0;
            assign fwd_dat[r] = '0;
`endif
            rf_read_lane #(
                .DW    (DW),
                .NREG  (NREG),
                .ZERO0 (ZERO0),
                .AW    (AW)
            ) u_lane (
                .mem     (mem),
                .rsel    (rsel[r*AW +: AW]),
                .fwd_hit (fwd_hit[r]),
                .fwd_dat (fwd_dat[r]),
                .rdat    (rdat[r*DW +: DW])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multiport_register_file.sv
// Bench for multiport_register_file (NWR=2, NRD=2): one instance with
// hardwired reg 0 and one without, sharing stimulus. A plain array model
// predicts reads, collision flags and counters; directed literal checks pin it.
// Honours RF_BYPASS_EN the same way the design does.
module tb_multiport_register_file;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [1:0]  wen;
    logic [9:0]  wsel;
    logic [63:0] wdat;
    logic [9:0]  rsel;
    logic [63:0] rdat1, rdat0;
    logic [1:0]  wcoll1, wcoll0;
    logic [15:0] wcnt1, wcnt0;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // model state
    logic [31:0] m [32];
    bit          claimed [32];
    logic [1:0]  ecoll;
    int          cnt1, cnt0;

    multiport_register_file #(.DW(32), .NREG(32), .NRD(2), .NWR(2), .ZERO0(1)) dut (
        .clk(clk), .n_rst(n_rst), .wen(wen), .wsel(wsel), .wdat(wdat),
        .rsel(rsel), .rdat(rdat1), .wcoll(wcoll1), .wcnt(wcnt1)
    );

    multiport_register_file #(.DW(32), .NREG(32), .NRD(2), .NWR(2), .ZERO0(0)) dut_z (
        .clk(clk), .n_rst(n_rst), .wen(wen), .wsel(wsel), .wdat(wdat),
        .rsel(rsel), .rdat(rdat0), .wcoll(wcoll0), .wcnt(wcnt0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] sat(input int c);
        return (c > 65535) ? 16'hFFFF : c[15:0];
    endfunction

    function automatic logic [31:0] exp_rd(input bit z, input logic [4:0] s);
        logic [31:0] v;
        v = m[s];
`ifdef RF_BYPASS_EN
        if (!n_rst)
            for (int p = 1; p >= 0; p--)
                if (wen[p] && wsel[p*5 +: 5] == s) v = wdat[p*32 +: 32];
`endif
        if (z && s == 5'd0) v = '0;
        return v;
    endfunction

    // Model: ports in priority order claim an index; first claimer writes.
    always @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            for (int i = 0; i < 32; i++) m[i] = '0;
            ecoll = '0;
            cnt1  = 0;
            cnt0  = 0;
        end else begin
            for (int i = 0; i < 32; i++) claimed[i] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                ecoll[p] = 1'b0;
                if (wen[p]) begin
                    if (claimed[wsel[p*5 +: 5]]) begin
                        ecoll[p] = 1'b1;
                    end else begin
                        claimed[wsel[p*5 +: 5]] = 1'b1;
                        m[wsel[p*5 +: 5]] = wdat[p*32 +: 32];
                        cnt0++;
                        if (wsel[p*5 +: 5] != 5'd0) cnt1++;
                    end
                end
            end
        end
    end

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int r = 0; r < 2; r++) begin
                chk($sformatf("rd_z1[%0d]", r), rdat1[r*32 +: 32], exp_rd(1'b1, rsel[r*5 +: 5]));
                chk($sformatf("rd_z0[%0d]", r), rdat0[r*32 +: 32], exp_rd(1'b0, rsel[r*5 +: 5]));
            end
            chk("wcoll_z1", wcoll1, ecoll);
            chk("wcoll_z0", wcoll0, ecoll);
            chk("wcnt_z1", wcnt1, sat(cnt1));
            chk("wcnt_z0", wcnt0, sat(cnt0));
        end
    end

    task automatic edge_drive();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_rst = 1'b1;
        wen = '0; wsel = '0; wdat = '0; rsel = '0;
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b0;
        chk_en = 1'b1;

        // reset: write r5, then assert reset mid-cycle
        wen = 2'b01; wsel = {5'd0, 5'd5}; wdat = {32'h0, 32'hDEAD}; rsel = {5'd5, 5'd5};
        edge_drive();
        wen = '0;
        @(negedge clk);
        chk("lit_rd_dead", rdat1[31:0], 32'hDEAD);
        @(posedge clk);
        #2 n_rst = 1'b1;
        #1;
        chk("lit_rst_rd", rdat1, 64'h0);
        chk("lit_rst_cnt", wcnt1, 16'h0);
        chk("lit_rst_coll", wcoll1, 2'b00);
        edge_drive();
        n_rst = 1'b0;

        // basic: two ports, different indices
        wen = 2'b11; wsel = {5'd7, 5'd3}; wdat = {32'h22, 32'h11};
        edge_drive();
        wen = '0; rsel = {5'd7, 5'd3};
        @(negedge clk);
        chk("lit_basic_rd", rdat1, {32'h22, 32'h11});
        chk("lit_basic_cnt", wcnt1, 16'd2);
        chk("lit_basic_coll", wcoll1, 2'b00);

        // collision on r9
        edge_drive();
        wen = 2'b11; wsel = {5'd9, 5'd9}; wdat = {32'hBB, 32'hAA};
        edge_drive();
        wen = '0; rsel = {5'd9, 5'd9};
        @(negedge clk);
        chk("lit_coll_rd", rdat1[31:0], 32'hAA);
        chk("lit_coll_flag", wcoll1, 2'b10);
        chk("lit_coll_cnt", wcnt1, 16'd3);
        edge_drive();
        @(negedge clk);
        chk("lit_coll_clear", wcoll1, 2'b00);

        // write to reg 0
        edge_drive();
        wen = 2'b01; wsel = {5'd0, 5'd0}; wdat = {32'h0, 32'hFFFF_FFFF};
        edge_drive();
        wen = '0; rsel = {5'd0, 5'd0};
        @(negedge clk);
        chk("lit_zero_z1", rdat1[31:0], 32'h0);
        chk("lit_zero_z0", rdat0[31:0], 32'hFFFF_FFFF);
        chk("lit_zero_cnt_z1", wcnt1, 16'd3);
        chk("lit_zero_cnt_z0", wcnt0, 16'd4);

        // both ports on reg 0: arbitration still applies
        edge_drive();
        wen = 2'b11; wsel = {5'd0, 5'd0}; wdat = {32'h1, 32'h2};
        edge_drive();
        wen = '0;
        @(negedge clk);
        chk("lit_zero_coll", wcoll1, 2'b10);
        chk("lit_zero_coll_cnt", wcnt1, 16'd3);

        // same-cycle read/write of r4
        edge_drive();
        wen = 2'b01; wsel = {5'd0, 5'd4}; wdat = {32'h0, 32'h55}; rsel = {5'd4, 5'd4};
        @(negedge clk);
`ifdef RF_BYPASS_EN
        chk("lit_byp_same", rdat1[31:0], 32'h55);
`else
        chk("lit_byp_same", rdat1[31:0], 32'h0);
`endif
        edge_drive();
        wen = '0;
        @(negedge clk);
        chk("lit_byp_next", rdat1[31:0], 32'h55);

        // randomized traffic with occasional mid-cycle reset
        for (int i = 0; i < 3000; i++) begin
            edge_drive();
            n_rst = 1'b0;
            wen = 2'($urandom);
            for (int p = 0; p < 2; p++) begin
                wsel[p*5 +: 5] = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
                rsel[p*5 +: 5] = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
                wdat[p*32 +: 32] = $urandom;
            end
            if ($urandom_range(0, 199) == 0) begin
                #2 n_rst = 1'b1;
            end
        end
        edge_drive();
        n_rst = 1'b0;
        wen = '0;

        // saturation: 70020 committed writes
        edge_drive();
        n_rst = 1'b1;
        edge_drive();
        n_rst = 1'b0;
        wsel = {5'd2, 5'd1};
        for (int i = 0; i < 35010; i++) begin
            wen = 2'b11;
            wdat = {$urandom, $urandom};
            edge_drive();
        end
        wen = '0;
        @(negedge clk);
        chk("lit_sat_z1", wcnt1, 16'hFFFF);
        chk("lit_sat_z0", wcnt0, 16'hFFFF);
        edge_drive();
        @(negedge clk);
        chk("lit_sat_hold", wcnt1, 16'hFFFF);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
